// File: rtl/mux_rr_nch.sv
// mux_rr_nch
//   N_CH-input, WIDTH-bit multiplexer with a single registered output stage
//   and valid/ready handshakes on every channel. Selection is either fixed
//   (external sel) or round-robin among requesting channels.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   per-channel request, bit i = channel i
//   in_data    channel i at [i*WIDTH +: WIDTH]
//   in_ready   one-hot or zero, asserted only for the granted channel
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel index used in fixed mode (out-of-range never grants)
//   out_valid  output register occupied
//   out_data   registered word
//   out_ch     channel that supplied out_data
//   out_ready  consumer accept
module mux_rr_nch #(
  parameter  int unsigned N_CH  = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  input  logic                  out_ready
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_ch;
  logic [SEL_W-1:0] r_rr_ptr;

  logic             w_can_load;
  logic             w_grant_vld;
  logic [SEL_W-1:0] w_grant_idx;
  logic [WIDTH-1:0] w_grant_data;
  logic             w_xfer;

  assign w_can_load = !r_out_valid || out_ready;
  assign w_xfer     = w_grant_vld && w_can_load;

  // Grant selection. In round-robin mode each channel gets a priority
  // distance from rr_ptr+1 (0 = highest); the valid channel with the
  // smallest distance wins.
  always_comb begin : p_grant
    int unsigned w_dist;
    int unsigned w_best;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_dist      = 0;
    w_best      = N_CH;
    if (!mode) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = SEL_W'(i);
        end
      end
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        w_dist = (i + N_CH - 32'(r_rr_ptr) - 1) % N_CH;
        if (in_valid[i] && w_dist < w_best) begin
          w_best      = w_dist;
          w_grant_vld = 1'b1;
          w_grant_idx = SEL_W'(i);
        end
      end
    end
  end

  always_comb begin
    w_grant_data = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (w_grant_idx == SEL_W'(i)) begin
        w_grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // rst_n gates in_ready so no handshake can complete while reset is held.
  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      in_ready[i] = rst_n && w_xfer && (w_grant_idx == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_rr_ptr    <= SEL_W'(N_CH - 1);
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_grant_data;
      r_out_ch    <= w_grant_idx;
      r_rr_ptr    <= w_grant_idx;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_mux_rr_nch.sv
module tb_mux_rr_nch;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT A: N_CH=4, WIDTH=8
  logic [3:0]  a_in_valid;
  logic [31:0] a_in_data;
  logic [3:0]  a_in_ready;
  logic        a_mode;
  logic [1:0]  a_sel;
  logic        a_out_valid;
  logic [7:0]  a_out_data;
  logic [1:0]  a_out_ch;
  logic        a_out_ready;

  // DUT B: N_CH=3, WIDTH=16
  logic [2:0]  b_in_valid;
  logic [47:0] b_in_data;
  logic [2:0]  b_in_ready;
  logic        b_mode;
  logic [1:0]  b_sel;
  logic        b_out_valid;
  logic [15:0] b_out_data;
  logic [1:0]  b_out_ch;
  logic        b_out_ready;

  mux_rr_nch #(.N_CH(4), .WIDTH(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .mode(a_mode), .sel(a_sel),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ch(a_out_ch),
    .out_ready(a_out_ready)
  );

  mux_rr_nch #(.N_CH(3), .WIDTH(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .mode(b_mode), .sel(b_sel),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ch(b_out_ch),
    .out_ready(b_out_ready)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state: contents of the output register plus last grant.
  bit         ma_valid;
  logic [7:0] ma_data;
  int         ma_ch;
  int         ma_last;
  bit          mb_valid;
  logic [15:0] mb_data;
  int          mb_ch;
  int          mb_last;

  // Grant rule: fixed picks sel if in range and requesting; round-robin
  // takes the first requester after the last grant, wrapping.
  function automatic int model_grant(input int n, input logic [15:0] v,
                                     input bit md, input int s, input int last);
    if (!md) return (s < n && v[s]) ? s : -1;
    for (int k = 1; k <= n; k++) begin
      if (v[(last + k) % n]) return (last + k) % n;
    end
    return -1;
  endfunction

  task automatic model_reset();
    ma_valid = 0; ma_data = '0; ma_ch = 0; ma_last = 3;
    mb_valid = 0; mb_data = '0; mb_ch = 0; mb_last = 2;
  endtask

  // One clock of DUT A: compare in_ready before the edge, advance the model
  // at the edge, compare the output register after it.
  task automatic cycle_a(input string tag);
    int g;
    bit can;
    logic [3:0] er;
    #1;
    can = !ma_valid || a_out_ready;
    g = rst_n ? model_grant(4, 16'(a_in_valid), a_mode, int'(a_sel), ma_last) : -1;
    er = (g >= 0 && can) ? 4'(1 << g) : 4'b0;
    total_cnt++;
    if (a_in_ready !== er) $display("FAIL %s a_in_ready got %b exp %b", tag, a_in_ready, er);
    else pass_cnt++;
    @(posedge clk);
    if (g >= 0 && can) begin
      ma_valid = 1; ma_data = a_in_data[g*8 +: 8]; ma_ch = g; ma_last = g;
    end else if (ma_valid && a_out_ready) begin
      ma_valid = 0;
    end
    #1;
    total_cnt++;
    if (a_out_valid !== ma_valid) $display("FAIL %s a_out_valid got %b exp %b", tag, a_out_valid, ma_valid);
    else pass_cnt++;
    total_cnt++;
    if (a_out_data !== ma_data) $display("FAIL %s a_out_data got %h exp %h", tag, a_out_data, ma_data);
    else pass_cnt++;
    total_cnt++;
    if (a_out_ch !== 2'(ma_ch)) $display("FAIL %s a_out_ch got %0d exp %0d", tag, a_out_ch, ma_ch);
    else pass_cnt++;
  endtask

  task automatic cycle_b(input string tag);
    int g;
    bit can;
    logic [2:0] er;
    #1;
    can = !mb_valid || b_out_ready;
    g = rst_n ? model_grant(3, 16'(b_in_valid), b_mode, int'(b_sel), mb_last) : -1;
    er = (g >= 0 && can) ? 3'(1 << g) : 3'b0;
    total_cnt++;
    if (b_in_ready !== er) $display("FAIL %s b_in_ready got %b exp %b", tag, b_in_ready, er);
    else pass_cnt++;
    @(posedge clk);
    if (g >= 0 && can) begin
      mb_valid = 1; mb_data = b_in_data[g*16 +: 16]; mb_ch = g; mb_last = g;
    end else if (mb_valid && b_out_ready) begin
      mb_valid = 0;
    end
    #1;
    total_cnt++;
    if (b_out_valid !== mb_valid) $display("FAIL %s b_out_valid got %b exp %b", tag, b_out_valid, mb_valid);
    else pass_cnt++;
    total_cnt++;
    if (b_out_data !== mb_data) $display("FAIL %s b_out_data got %h exp %h", tag, b_out_data, mb_data);
    else pass_cnt++;
    total_cnt++;
    if (b_out_ch !== 2'(mb_ch)) $display("FAIL %s b_out_ch got %0d exp %0d", tag, b_out_ch, mb_ch);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 4'($urandom); a_in_data = $urandom; a_mode = 1'($urandom);
    a_sel = 2'($urandom); a_out_ready = 1'($urandom);
    b_in_valid = 3'b111; b_in_data = 48'h0000_2222_1111_0000; b_mode = 1'b1;
    b_sel = 2'd0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL rst a_out_valid got %b exp 0", a_out_valid); else pass_cnt++;
    total_cnt++; if (a_out_data !== 8'h00) $display("FAIL rst a_out_data got %h exp 00", a_out_data); else pass_cnt++;
    total_cnt++; if (a_out_ch !== 2'd0) $display("FAIL rst a_out_ch got %0d exp 0", a_out_ch); else pass_cnt++;
    total_cnt++; if (a_in_ready !== 4'b0) $display("FAIL rst a_in_ready got %b exp 0000", a_in_ready); else pass_cnt++;
    total_cnt++; if (b_in_ready !== 3'b0) $display("FAIL rst b_in_ready got %b exp 000", b_in_ready); else pass_cnt++;
    total_cnt++; if (b_out_valid !== 1'b0) $display("FAIL rst b_out_valid got %b exp 0", b_out_valid); else pass_cnt++;
    b_in_valid = 3'b000;
    rst_n = 1'b1;
    model_reset();
    a_mode = 1'b1; a_in_valid = 4'hF; a_out_ready = 1'b1;
    cycle_a("rst_first_rr");
    total_cnt++; if (a_out_ch !== 2'd0) $display("FAIL rst_first_rr out_ch got %0d exp 0", a_out_ch); else pass_cnt++;
  endtask

  task automatic test_fixed();
    a_mode = 1'b0; a_sel = 2'd2; a_in_valid = 4'b0100;
    a_in_data = 32'h00A5_0000; a_out_ready = 1'b1;
    #1;
    total_cnt++; if (a_in_ready !== 4'b0100) $display("FAIL fixed in_ready got %b exp 0100", a_in_ready); else pass_cnt++;
    cycle_a("fixed_sel2");
    total_cnt++; if (a_out_data !== 8'hA5) $display("FAIL fixed out_data got %h exp a5", a_out_data); else pass_cnt++;
    total_cnt++; if (a_out_ch !== 2'd2) $display("FAIL fixed out_ch got %0d exp 2", a_out_ch); else pass_cnt++;
    a_in_valid = 4'b1011;
    cycle_a("fixed_nogrant");
    total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL fixed_nogrant out_valid got %b exp 0", a_out_valid); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    a_in_data = 32'h1312_1110; a_in_valid = 4'hF; a_out_ready = 1'b1;
    a_mode = 1'b0; a_sel = 2'd3;
    cycle_a("rr_prime");
    a_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle_a("rr_all");
      total_cnt++;
      if (a_out_valid !== 1'b1 || a_out_ch !== 2'(i % 4) || a_out_data !== 8'(8'h10 + i % 4))
        $display("FAIL rr_seq[%0d] got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h",
                 i, a_out_valid, a_out_ch, a_out_data, i % 4, 8'h10 + i % 4);
      else pass_cnt++;
    end
  endtask

  task automatic test_sparse();
    a_mode = 1'b1; a_in_valid = 4'b1010; a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total_cnt++;
      if ((a_in_ready & 4'b0101) !== 4'b0) $display("FAIL sparse idle_ready got %b exp x0x0", a_in_ready);
      else pass_cnt++;
      cycle_a("sparse");
      total_cnt++;
      if (a_out_ch !== ((i % 2) ? 2'd3 : 2'd1))
        $display("FAIL sparse_seq[%0d] got %0d exp %0d", i, a_out_ch, (i % 2) ? 3 : 1);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    logic [1:0] held_ch;
    a_mode = 1'b1; a_in_valid = 4'hF; a_in_data = 32'h1312_1110; a_out_ready = 1'b1;
    cycle_a("bp_fill");
    held = a_out_data; held_ch = a_out_ch;
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++; if (a_in_ready !== 4'b0) $display("FAIL bp_hold in_ready got %b exp 0000", a_in_ready); else pass_cnt++;
      cycle_a("bp_hold");
      total_cnt++;
      if (a_out_valid !== 1'b1 || a_out_data !== held)
        $display("FAIL bp_stable got v=%b d=%h exp v=1 d=%h", a_out_valid, a_out_data, held);
      else pass_cnt++;
    end
    a_out_ready = 1'b1;
    cycle_a("bp_release");
    total_cnt++;
    if (a_out_valid !== 1'b1 || a_out_ch !== 2'(held_ch + 2'd1))
      $display("FAIL bp_no_bubble got v=%b ch=%0d exp v=1 ch=%0d", a_out_valid, a_out_ch, 2'(held_ch + 2'd1));
    else pass_cnt++;
  endtask

  task automatic test_mode_switch();
    a_mode = 1'b0; a_sel = 2'd2; a_in_valid = 4'hF; a_out_ready = 1'b1;
    cycle_a("ms_fixed");
    total_cnt++; if (a_out_ch !== 2'd2) $display("FAIL ms_fixed out_ch got %0d exp 2", a_out_ch); else pass_cnt++;
    a_mode = 1'b1;
    cycle_a("ms_rr");
    total_cnt++; if (a_out_ch !== 2'd3) $display("FAIL ms_rr out_ch got %0d exp 3", a_out_ch); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    a_mode = 1'b1; a_in_valid = 4'hF; a_out_ready = 1'b0;
    cycle_a("rm_full");
    total_cnt++; if (a_out_valid !== 1'b1) $display("FAIL rm_full out_valid got %b exp 1", a_out_valid); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL rm_async out_valid got %b exp 0", a_out_valid); else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    a_in_valid = 4'b0;
    a_out_ready = 1'b1;
    cycle_a("rm_after");
  endtask

  task automatic test_param_sweep();
    b_mode = 1'b1; b_in_valid = 3'b111; b_in_data = 48'h3302_2201_1100; b_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle_b("n3_rr");
      total_cnt++;
      if (b_out_ch !== 2'(i % 3) || b_out_data !== 16'(16'h1100 + (i % 3) * 16'h1101))
        $display("FAIL n3_rr_seq[%0d] got ch=%0d d=%h exp ch=%0d", i, b_out_ch, b_out_data, i % 3);
      else pass_cnt++;
    end
    b_mode = 1'b0; b_sel = 2'd3;
    #1;
    total_cnt++; if (b_in_ready !== 3'b0) $display("FAIL n3_sel3 in_ready got %b exp 000", b_in_ready); else pass_cnt++;
    cycle_b("n3_sel3");
    total_cnt++; if (b_out_valid !== 1'b0) $display("FAIL n3_sel3 out_valid got %b exp 0", b_out_valid); else pass_cnt++;
    b_sel = 2'd1;
    cycle_b("n3_sel1");
    total_cnt++;
    if (b_out_ch !== 2'd1 || b_out_data !== 16'h2201)
      $display("FAIL n3_sel1 got ch=%0d d=%h exp ch=1 d=2201", b_out_ch, b_out_data);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      a_in_valid = 4'($urandom); a_in_data = $urandom; a_mode = ($urandom_range(0, 3) != 0);
      a_sel = 2'($urandom); a_out_ready = ($urandom_range(0, 3) != 0);
      cycle_a("rand_a");
    end
    for (int i = 0; i < 200; i++) begin
      b_in_valid = 3'($urandom); b_in_data = 48'({$urandom, $urandom}); b_mode = 1'($urandom);
      b_sel = 2'($urandom); b_out_ready = ($urandom_range(0, 3) != 0);
      cycle_b("rand_b");
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_sparse();
    test_backpressure();
    test_mode_switch();
    test_reset_mid();
    test_param_sweep();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mux_rr_nch.md
# mux_rr_nch

Parametrised N-channel, W-bit multiplexer with a registered output and valid/ready handshakes on every channel. Selection is either fixed, driven by an external `sel` bus, or round-robin arbitration among requesting channels. It replaces the fixed 4:1 single-bit gate-level selector wherever a multi-bit, flow-controlled datapath merges several producers into one consumer.

## Interface
- `N_CH`, 4, number of input channels (2..16)
- `WIDTH`, 8, data width per channel (1..64)
- `SEL_W`, $clog2(N_CH), width of `sel` and `out_ch` (derived, not overridden)

- `clk`  in  1  rising-edge clock, the only clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  N_CH  per-channel request; bit i belongs to channel i
- `in_data`  in  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- `in_ready`  out  N_CH  one-hot or zero; a channel transfers when its valid and ready are both 1
- `mode`  in  1  0 = fixed select, 1 = round-robin
- `sel`  in  SEL_W  channel index used when `mode`=0
- `out_valid`  out  1  output register holds a word
- `out_data`  out  WIDTH  registered word
- `out_ch`  out  SEL_W  index of the channel that supplied `out_data`
- `out_ready`  in  1  consumer accepts when `out_valid` and `out_ready` are both 1

## Operation
- Single output register, with occupancy given by `out_valid`. The register can load when `can_load` = !out_valid | out_ready.
- Grant is combinational from the current inputs and state:
  - `mode`=0: grant channel `sel` iff `in_valid[sel]` and `sel` < N_CH. Otherwise there is no grant. An out-of-range `sel` never grants.
  - `mode`=1: grant the first channel with `in_valid` set, searching from `rr_ptr`+1 upward and wrapping modulo N_CH. `rr_ptr` is the last granted channel.
- `in_ready[g]` = `can_load` for the granted channel g. All other `in_ready` bits are 0. `in_ready` never depends on `in_valid` of a non-granted channel.
- On a transfer from channel g:
  - `out_data` <= channel g data, `out_ch` <= g, `out_valid` <= 1.
  - `rr_ptr` <= g in both modes, so a switch to round-robin continues fairly from the last grant.
- If `out_valid` and `out_ready` are both 1 and there is no grant: `out_valid` <= 0. `out_data` and `out_ch` hold their stale values.
- If `out_valid`=1 and `out_ready`=0: the register holds and every `in_ready` bit is 0.
- Simultaneous drain and load in the same cycle is allowed and gives full throughput, one word per cycle.
- Changes to `mode` or `sel` are sampled on each cycle's grant. They never corrupt a word already held in the register.
- Reset (asynchronous assert, synchronous release by the system):
  - `out_valid`=0, `out_data`=0, `out_ch`=0, `rr_ptr`=N_CH-1, so channel 0 has first priority.
  - Reset asserted mid-transfer discards the held word. No partial state survives.

## Timing
- Latency: 1 cycle from the input transfer edge to `out_valid`/`out_data` at the output.
- Throughput: 1 word per cycle while `out_ready`=1 and a grant exists.
- Combinational paths:
  - `in_valid`/`mode`/`sel`/`out_ready` -> `in_ready`.
  - There is no combinational path from any input to `out_valid`, `out_data` or `out_ch`.
- Round-robin fairness: with all N_CH channels continuously valid and `out_ready`=1, each channel is granted exactly once every N_CH cycles.

## Test plan
- Reset: hold `rst_n`=0 with arbitrary inputs, then release.
  - Required: `out_valid`=0, `out_data`=0, `out_ch`=0 and `in_ready`=0 during reset.
  - Required: the first round-robin grant, with all channels valid, goes to channel 0.
- Fixed mode, N_CH=4, WIDTH=8, `sel`=2, ch2 data 0xA5 valid, `out_ready`=1.
  - Required: `in_ready`=4'b0100 and, next cycle, `out_data`=0xA5, `out_ch`=2.
  - With `in_valid[2]`=0 and other channels valid: no grant, and `out_valid` drops after the drain.
- Round-robin, all 4 channels valid with data 0x10..0x13, `out_ready`=1 for 8 cycles.
  - Required: `out_ch` sequence 0,1,2,3,0,1,2,3 and one word per cycle.
- Sparse round-robin, only ch1 and ch3 valid.
  - Required: grants alternate 1,3,1,3. Ch0 and ch2 never see `in_ready`=1.
- Backpressure: `out_ready`=0 for 3 cycles with the register full.
  - Required: `out_data` stable, `in_ready`=0.
  - Required: on release, the held word drains and the next grant loads in the same cycle with no bubble.
- Mode switch and reset mid-stream.
  - Switch `mode` from 0 to 1 right after a grant to ch2. Required: the next round-robin grant goes to ch3.
  - Assert `rst_n` while `out_valid`=1. Required: `out_valid` falls to 0 immediately, asynchronously.
- Parameter sweep.
  - Repeat the round-robin and fixed-mode scenarios with N_CH=3 and WIDTH=16.
  - Required: `sel`=3 produces no grant, and the round-robin order 0,1,2 wraps correctly.
